bw_mul_arbiter: RTL

Shares one combinational 8x8 signed Baugh-Wooley multiplier (`baughwooley8`) between NREQ requesters. Each requester presents signed operands with a valid/ready handshake. The block grants requesters round-robin, registers the granted operands into the multiplier, registers the 16-bit signed product, and returns it with the requester's id over a valid/ready response channel. It sits between the multiply-issuing clients and the single multiplier instance.

---
 rtl/bw_mul_pkg.sv | 11 +
 rtl/baughwooley8.sv | 34 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/bw_mul_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/bw_mul_pkg.sv
// Shared widths and controller state encoding for the shared-multiplier arbiter.
package bw_mul_pkg;
   localparam int OPW = 8;
   localparam int PW  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/baughwooley8.sv
// Combinational 8x8 signed multiplier using the Baugh-Wooley partial-product array.
module baughwooley8
   import bw_mul_pkg::*;
(
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   output logic [PW-1:0]  p
);
   logic [PW-1:0] row [OPW];

   genvar gi, gj;
   generate
      for (gi = 0; gi < OPW; gi++) begin : g_row
         logic [OPW-1:0] bits;
         for (gj = 0; gj < OPW; gj++) begin : g_bit
            // Terms mixing exactly one sign bit enter inverted.
            if ((gi == OPW-1) != (gj == OPW-1)) begin : g_inv
               assign bits[gj] = ~(a[gj] & b[gi]);
            end else begin : g_pos
               assign bits[gj] = a[gj] & b[gi];
            end
         end
         assign row[gi] = {{(PW-OPW){1'b0}}, bits} << gi;
      end
   endgenerate

   // Correction constant 2^8 + 2^15 completes the two's-complement sum.
   always_comb begin
      p = 16'h8100;
      for (int k = 0; k < OPW; k++) begin
         p = p + row[k];
      end
   end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; priority starts one past ptr and wraps modulo N.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic          en,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);
   int cand;

   // Scan lowest priority first so the highest-priority hit is written last.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      cand    = 0;
      if (en) begin
         for (int k = N; k >= 1; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
               gnt       = '0;
               gnt[cand] = 1'b1;
               gnt_idx   = IW'(cand);
            end
         end
      end
   end
endmodule

// File: rtl/bw_mul_arbiter.sv
// Round-robin sharing of one signed 8x8 multiplier among NREQ requesters,
// with registered operands, registered product and a valid/ready response.
module bw_mul_arbiter
   import bw_mul_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_x,
   input  logic [NREQ*8-1:0] req_y,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [15:0]       rsp_p
);
   state_t state_reg, state_next;

   logic [OPW-1:0] op_x_reg, op_y_reg;
   logic [IDW-1:0] id_reg, last_reg, rsp_id_reg;
   logic [PW-1:0]  rsp_p_reg;
   logic [PW-1:0]  mul_p;

   logic [OPW-1:0]  x_arr [NREQ];
   logic [OPW-1:0]  y_arr [NREQ];
   logic            window;
   logic            accept;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign x_arr[gi] = req_x[gi*OPW +: OPW];
         assign y_arr[gi] = req_y[gi*OPW +: OPW];
      end
   endgenerate

   // Grants open only when no product would be lost; held shut during reset.
   assign window = rst_n && ((state_reg == IDLE) || ((state_reg == DONE) && rsp_ready));

   rr_arbiter #(
      .N  (NREQ),
      .IW (IDW)
   ) u_arb (
      .req     (req_valid),
      .en      (window),
      .ptr     (last_reg),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign accept    = |gnt;
   assign req_ready = gnt;

   baughwooley8 u_mul (
      .a (op_x_reg),
      .b (op_y_reg),
      .p (mul_p)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = MUL;
         MUL:  state_next = DONE;
         DONE: if (rsp_ready) state_next = accept ? MUL : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         op_x_reg   <= '0;
         op_y_reg   <= '0;
         id_reg     <= '0;
         last_reg   <= IDW'(NREQ - 1);
         rsp_p_reg  <= '0;
         rsp_id_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_x_reg <= x_arr[gnt_idx];
            op_y_reg <= y_arr[gnt_idx];
            id_reg   <= gnt_idx;
            last_reg <= gnt_idx;
         end
         if (state_reg == MUL) begin
            rsp_p_reg  <= mul_p;
            rsp_id_reg <= id_reg;
         end
      end
   end

   assign rsp_valid = (state_reg == DONE);
   assign rsp_p     = rsp_p_reg;
   assign rsp_id    = rsp_id_reg;
endmodule
